// File: rtl/seq_mul16.sv
// rtl/seq_mul16.sv - 16x16 sequential shift-add multiplier, 18 cycles start-to-done
// Build option: define MUL_SIGNED_EN for two's-complement operands (magnitude
// multiply with sign applied in FIX); undefined gives a plain unsigned multiplier.

module seq_mul16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product,
   output logic        ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] mcand_q, mcand_d;
   logic [15:0] mplr_q, mplr_d;
   logic [15:0] acc_q, acc_d;
   logic [31:0] product_q, product_d;
   logic        ovf_q, ovf_d;

   logic [15:0] a_mag;
   logic [15:0] b_mag;
   logic [15:0] addend;
   logic [16:0] sum17;
   logic [31:0] result;
   logic        result_ovf;

`ifdef MUL_SIGNED_EN
   logic        sign_q, sign_d;

   // Operand magnitudes; 0x8000 maps to itself, which is its correct unsigned magnitude
   always_comb begin
      a_mag = a[15] ? (~a + 16'd1) : a;
      b_mag = b[15] ? (~b + 16'd1) : b;
   end

   // Re-apply the product sign and flag results outside the signed 16-bit range
   always_comb begin
      result     = sign_q ? (~{acc_q, mplr_q} + 32'd1) : {acc_q, mplr_q};
      result_ovf = (result[31:16] != {16{result[15]}});
   end
`else
   // Unsigned operands are used as-is
   always_comb begin
      a_mag = a;
      b_mag = b;
   end

   // Magnitude is the product; overflow when any upper-half bit is set
   always_comb begin
      result     = {acc_q, mplr_q};
      result_ovf = |result[31:16];
   end
`endif

   // Ripple-carry add of the multiplicand into the upper accumulator half, carry kept as bit 16
   always_comb begin
      logic c;
      addend = mplr_q[0] ? mcand_q : 16'd0;
      c      = 1'b0;
      sum17  = '0;
      for (int i = 0; i < 16; i++) begin
         sum17[i] = acc_q[i] ^ addend[i] ^ c;
         c        = (acc_q[i] & addend[i]) | (acc_q[i] & c) | (addend[i] & c);
      end
      sum17[16] = c;
   end

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      product_d = product_q;
      ovf_d     = ovf_q;
`ifdef MUL_SIGNED_EN
      sign_d    = sign_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d = a_mag;
               mplr_d  = b_mag;
               acc_d   = 16'd0;
               cnt_d   = 4'd0;
`ifdef MUL_SIGNED_EN
               sign_d  = a[15] ^ b[15];
`endif
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Shift {carry, acc, multiplier} right by one; the carry lands in acc[15]
            acc_d  = sum17[16:1];
            mplr_d = {sum17[0], mplr_q[15:1]};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            product_d = result;
            ovf_d     = result_ovf;
            state_d   = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register with synchronous active-high reset; reset wins over a same-cycle start
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         mcand_q   <= 16'd0;
         mplr_q    <= 16'd0;
         acc_q     <= 16'd0;
         product_q <= 32'd0;
         ovf_q     <= 1'b0;
`ifdef MUL_SIGNED_EN
         sign_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
`ifdef MUL_SIGNED_EN
         sign_q    <= sign_d;
`endif
      end
   end

   // Status decoded from state; result outputs come straight from their registers
   always_comb begin
      busy    = (state_q == S_RUN) || (state_q == S_FIX);
      done    = (state_q == S_DONE);
      product = product_q;
      ovf     = ovf_q;
   end

endmodule

// File: tb/tb_seq_mul16.sv
// tb/tb_seq_mul16.sv - self-checking bench for seq_mul16 against an arithmetic reference

module tb_seq_mul16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;
   logic        ovf;

   int n_vec = 0;
   int n_err = 0;

   seq_mul16 dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   // Reference: full-precision multiply, overflow when the value leaves the 16-bit range
   function automatic logic [32:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      logic [31:0] p;
      logic        o;
`ifdef MUL_SIGNED_EN
      int sp;
      sp = int'($signed(x)) * int'($signed(y));
      p  = sp;
      o  = (sp > 32767) || (sp < -32768);
`else
      longint up;
      up = longint'(x) * longint'(y);
      p  = up[31:0];
      o  = (up > 65535);
`endif
      return {o, p};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Issue one start, scramble operands after accept, wait (bounded) for done
   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib,
                        output logic [31:0] p, output logic o,
                        output int lat, output int busy_cnt);
      start = 1'b1;
      a     = ia;
      b     = ib;
      step();
      start    = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      lat      = 1;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         step();
         lat++;
      end
      p = product;
      o = ovf;
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      start = 1'b1;
      a     = 16'h1234;
      b     = 16'h5678;
      repeat (3) step();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0 || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL reset: busy=%b done=%b product=%h ovf=%b, required 0 0 00000000 0",
                  busy, done, product, ovf);
      end
   endtask

   task automatic test_basic;
      logic [31:0] p;
      logic        o;
      int          lat, bc;
      rst = 1'b0;
      do_op(16'h0003, 16'h0005, p, o, lat, bc);
      n_vec++;
      if (p !== 32'h0000000F || o !== 1'b0) begin
         n_err++;
         $display("FAIL basic_3x5: product=%h ovf=%b, required 0000000f 0", p, o);
      end
      n_vec++;
      if (lat !== 18) begin
         n_err++;
         $display("FAIL basic_latency: done at cycle %0d, required 18", lat);
      end
      n_vec++;
      if (bc !== 17) begin
         n_err++;
         $display("FAIL basic_busy: busy for %0d cycles, required 17", bc);
      end
      step();
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL basic_done_pulse: done=%b one cycle later, required 0", done);
      end
   endtask

   task automatic test_corners;
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic [31:0] vp [3];
      logic        vo [3];
      int          nv;
      logic [31:0] p;
      logic        o;
      int          lat, bc;
`ifdef MUL_SIGNED_EN
      nv = 3;
      va[0] = 16'hFFFF; vb[0] = 16'hFFFF; vp[0] = 32'h00000001; vo[0] = 1'b0;
      va[1] = 16'h8000; vb[1] = 16'h8000; vp[1] = 32'h40000000; vo[1] = 1'b1;
      va[2] = 16'h8000; vb[2] = 16'h0001; vp[2] = 32'hFFFF8000; vo[2] = 1'b0;
`else
      nv = 2;
      va[0] = 16'hFFFF; vb[0] = 16'hFFFF; vp[0] = 32'hFFFE0001; vo[0] = 1'b1;
      va[1] = 16'h0000; vb[1] = 16'hFFFF; vp[1] = 32'h00000000; vo[1] = 1'b0;
      va[2] = 16'h0000; vb[2] = 16'h0000; vp[2] = 32'h00000000; vo[2] = 1'b0;
`endif
      for (int i = 0; i < nv; i++) begin
         do_op(va[i], vb[i], p, o, lat, bc);
         n_vec++;
         if (p !== vp[i] || o !== vo[i] || lat !== 18) begin
            n_err++;
            $display("FAIL corner_%0d: a=%h b=%h product=%h ovf=%b lat=%0d, required %h %b 18",
                     i, va[i], vb[i], p, o, lat, vp[i], vo[i]);
         end
         step();
      end
   endtask

   task automatic test_random;
      logic [15:0] ra, rb;
      logic [32:0] exp;
      logic [31:0] p;
      logic        o;
      int          lat, bc;
      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 8 == 3) ra = 16'd0;
         if (i % 8 == 5) rb = 16'd0;
         if (i % 8 == 6) ra = 16'h8000;
         exp = ref_mul(ra, rb);
         do_op(ra, rb, p, o, lat, bc);
         n_vec++;
         if (p !== exp[31:0] || o !== exp[32]) begin
            n_err++;
            $display("FAIL random_%0d: a=%h b=%h product=%h ovf=%b, required %h %b",
                     i, ra, rb, p, o, exp[31:0], exp[32]);
         end
         n_vec++;
         if (lat !== 18 || bc !== 17) begin
            n_err++;
            $display("FAIL random_timing_%0d: lat=%0d busy=%0d, required 18 17", i, lat, bc);
         end
         step();
      end
   endtask

   task automatic test_back_to_back;
      int t;
      start = 1'b1;
      a     = 16'd2;
      b     = 16'd3;
      step();
      repeat (5) step();
      a = 16'd7;
      t = 6;
      while (!done && t < 40) begin
         step();
         t++;
      end
      n_vec++;
      if (done !== 1'b1 || product !== 32'd6 || t !== 18) begin
         n_err++;
         $display("FAIL b2b_first: done=%b product=%h at cycle %0d, required 1 00000006 18",
                  done, product, t);
      end
      step();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_idle_gap: busy=%b done=%b, required 0 0", busy, done);
      end
      t = 1;
      while (!done && t < 40) begin
         step();
         t++;
      end
      n_vec++;
      if (done !== 1'b1 || product !== 32'h15 || ovf !== 1'b0 || t !== 19) begin
         n_err++;
         $display("FAIL b2b_second: done=%b product=%h ovf=%b gap=%0d, required 1 00000015 0 19",
                  done, product, ovf, t);
      end
      start = 1'b0;
      step();
   endtask

   task automatic test_reset_abort;
      logic [31:0] p;
      logic        o;
      int          lat, bc;
      logic        saw_done;
      start = 1'b1;
      a     = 16'd9;
      b     = 16'd9;
      step();
      start = 1'b0;
      repeat (5) step();
      rst   = 1'b1;
      start = 1'b1;
      step();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0 || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL abort_reset: busy=%b done=%b product=%h ovf=%b, required 0 0 00000000 0",
                  busy, done, product, ovf);
      end
      rst      = 1'b0;
      start    = 1'b0;
      saw_done = 1'b0;
      repeat (25) begin
         step();
         if (done || busy) saw_done = 1'b1;
      end
      n_vec++;
      if (saw_done !== 1'b0) begin
         n_err++;
         $display("FAIL abort_no_done: activity seen after abort=%b, required 0", saw_done);
      end
      do_op(16'd4, 16'd4, p, o, lat, bc);
      n_vec++;
      if (p !== 32'h10 || o !== 1'b0 || lat !== 18) begin
         n_err++;
         $display("FAIL abort_restart: product=%h ovf=%b lat=%0d, required 00000010 0 18", p, o, lat);
      end
      step();
   endtask

   task automatic test_hold;
      logic [15:0] ra, rb;
      logic [32:0] exp;
      logic [31:0] p;
      logic        o;
      int          lat, bc;
      ra  = 16'($urandom_range(256, 65535));
      rb  = 16'($urandom_range(256, 65535));
      exp = ref_mul(ra, rb);
      do_op(ra, rb, p, o, lat, bc);
      step();
      for (int i = 0; i < 10; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         step();
         n_vec++;
         if (product !== exp[31:0] || ovf !== exp[32] || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL hold_%0d: product=%h ovf=%b busy=%b done=%b, required %h %b 0 0",
                     i, product, ovf, busy, done, exp[31:0], exp[32]);
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = 16'd0;
      b     = 16'd0;
      test_reset();
      test_basic();
      test_corners();
      test_random();
      test_back_to_back();
      test_reset_abort();
      test_hold();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
